// File: rtl/uart_inst_loader.sv
// UART (8N1) receiver that assembles four little-endian bytes into a 32-bit
// instruction word and offers it on a valid/ready handshake.
//
// state   | meaning
// S_IDLE  | waiting for a falling edge on rx
// S_START | half-bit wait, then confirm start bit is still low
// S_DATA  | sampling 8 data bits, LSB first, one per bit period
// S_STOP  | sampling stop bit, then back to idle
module uart_inst_loader #(
  parameter int CLKS_PER_BIT = 208,
  parameter int TIMEOUT_CLKS = 2_400_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  output logic [31:0] inst_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        frame_err,
  output logic        overrun,
  input  logic        overrun_clr
);

  localparam int BIT_W  = ($clog2(CLKS_PER_BIT) > 0) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDLE_W = ($clog2(TIMEOUT_CLKS) > 0) ? $clog2(TIMEOUT_CLKS) : 1;

  localparam logic [BIT_W-1:0]  BIT_TC  = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  HALF_TC = BIT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDLE_W-1:0] IDLE_TC = IDLE_W'(TIMEOUT_CLKS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]        r_sync;
  logic              r_rx_prev;
  logic [1:0]        r_state;
  logic [BIT_W-1:0]  r_bit_tmr;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_word;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [31:0]       r_inst_data;
  logic              r_inst_valid;
  logic              r_frame_err;
  logic              r_overrun;

  logic        w_rx;
  logic        w_fall;
  logic        w_tick;
  logic        w_stop_smp;
  logic        w_byte_stb;
  logic        w_frame_bad;
  logic        w_idle_run;
  logic        w_idle_tc;
  logic        w_complete;
  logic        w_load;
  logic        w_drop;
  logic [31:0] w_word_full;

  assign w_rx        = r_sync[1];
  assign w_fall      = r_rx_prev & ~w_rx;
  assign w_tick      = (r_bit_tmr == '0);
  assign w_stop_smp  = (r_state == S_STOP) && w_tick;
  assign w_byte_stb  = w_stop_smp & w_rx;
  assign w_frame_bad = w_stop_smp & ~w_rx;
  assign w_idle_run  = (r_state == S_IDLE) && (r_byte_cnt != 2'd0) && !w_fall;
  assign w_idle_tc   = w_idle_run && (r_idle_cnt == IDLE_TC);
  assign w_complete  = w_byte_stb && (r_byte_cnt == 2'd3);
  assign w_load      = w_complete && (!r_inst_valid || inst_ready);
  assign w_drop      = w_complete && r_inst_valid && !inst_ready;
  assign w_word_full = {r_shift, r_word};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], rxd};
      r_rx_prev <= w_rx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_tmr <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bit_tmr <= '0;
          if (w_fall) begin
            r_state   <= S_START;
            r_bit_tmr <= HALF_TC;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (!w_rx) begin
              r_state   <= S_DATA;
              r_bit_tmr <= BIT_TC;
              r_bit_idx <= 3'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_bit_tmr <= r_bit_tmr - 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift   <= {w_rx, r_shift[7:1]};
            r_bit_tmr <= BIT_TC;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_bit_tmr <= r_bit_tmr - 1'b1;
          end
        end
        default: begin
          if (w_tick) begin
            r_state <= S_IDLE;
          end else begin
            r_bit_tmr <= r_bit_tmr - 1'b1;
          end
        end
      endcase
    end
  end

  // Byte assembly; bytes 0..2 are staged, byte 3 goes straight into the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_cnt <= 2'd0;
      r_word     <= 24'd0;
    end else if (w_frame_bad || w_idle_tc) begin
      r_byte_cnt <= 2'd0;
    end else if (w_byte_stb) begin
      case (r_byte_cnt)
        2'd0:    r_word[7:0]   <= r_shift;
        2'd1:    r_word[15:8]  <= r_shift;
        2'd2:    r_word[23:16] <= r_shift;
        default: r_word        <= r_word;
      endcase
      r_byte_cnt <= r_byte_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle_cnt <= '0;
    end else if (w_fall || w_idle_tc || (r_byte_cnt == 2'd0)) begin
      r_idle_cnt <= '0;
    end else if (w_idle_run) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inst_data  <= 32'd0;
      r_inst_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      if (w_load) begin
        r_inst_data  <= w_word_full;
        r_inst_valid <= 1'b1;
      end else if (r_inst_valid && inst_ready) begin
        r_inst_valid <= 1'b0;
      end
      // A drop in the same cycle as a clear request leaves the flag set.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign inst_data  = r_inst_data;
  assign inst_valid = r_inst_valid;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_inst_loader.sv
// Directed bench for uart_inst_loader at 16 clocks per bit, 1000-cycle timeout.
module tb_uart_inst_loader;

  localparam int BIT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rxd;
  logic [31:0] inst_data;
  logic        inst_valid;
  logic        inst_ready;
  logic        frame_err;
  logic        overrun;
  logic        overrun_clr;

  int n_checks = 0;
  int n_errors = 0;

  uart_inst_loader #(.CLKS_PER_BIT(BIT), .TIMEOUT_CLKS(1000)) dut (
    .clk(clk), .reset(reset), .rxd(rxd),
    .inst_data(inst_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .frame_err(frame_err), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int          mon_vcnt = 0;
  int          mon_fcnt = 0;
  int          mon_first_v = 0;
  int          mon_viol = 0;
  logic [31:0] mon_last = 32'd0;
  logic        mon_pv = 1'b0;
  logic        mon_pr = 1'b0;
  logic [31:0] mon_pd = 32'd0;

  always @(negedge clk) begin
    if (inst_valid && !mon_pv) mon_first_v = cyc;
    if (inst_valid) begin
      mon_vcnt++;
      mon_last = inst_data;
    end
    if (frame_err) mon_fcnt++;
    if (mon_pv && !mon_pr && inst_data !== mon_pd) mon_viol++;
    mon_pv = inst_valid;
    mon_pr = inst_ready;
    mon_pd = inst_data;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int last_start_cyc = 0;

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    last_start_cyc = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  int v0;
  int f0;

  initial begin
    rxd = 1'b1;
    reset = 1'b1;
    inst_ready = 1'b0;
    overrun_clr = 1'b0;
    repeat (4) @(negedge clk);
    chk_val("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk_val("rst_data", inst_data, 32'd0);
    chk_val("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk_val("rst_ovr", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Single word, consumer always ready; valid expected 155 clocks after start edge drive.
    inst_ready = 1'b1;
    v0 = mon_vcnt;
    send_word(32'h0000_0013);
    repeat (20) @(negedge clk);
    chk_val("w1_data", mon_last, 32'h0000_0013);
    chk_val("w1_vcycles", mon_vcnt - v0, 32'd1);
    chk_val("w1_latency", mon_first_v - last_start_cyc, 32'd155);
    chk_val("w1_valid_low", {31'd0, inst_valid}, 32'd0);

    // Backpressure: first word held, second dropped.
    inst_ready = 1'b0;
    send_word(32'h0010_0093);
    repeat (5) @(negedge clk);
    chk_val("bp_valid", {31'd0, inst_valid}, 32'd1);
    chk_val("bp_data1", inst_data, 32'h0010_0093);
    chk_val("bp_ovr0", {31'd0, overrun}, 32'd0);
    send_word(32'h0020_8113);
    repeat (5) @(negedge clk);
    chk_val("bp_data_held", inst_data, 32'h0010_0093);
    chk_val("bp_ovr1", {31'd0, overrun}, 32'd1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk_val("bp_ovr_clr", {31'd0, overrun}, 32'd0);

    // Clear request lands exactly on the completion cycle: set must win.
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    fork
      send_byte(8'h04, 1'b1);
      begin
        repeat (154) @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    chk_val("ovr_set_wins", {31'd0, overrun}, 32'd1);
    chk_val("bp_data_held2", inst_data, 32'h0010_0093);
    chk_val("bp_stable", mon_viol, 32'd0);
    overrun_clr = 1'b1;
    inst_ready = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    @(negedge clk);
    chk_val("hs_valid_clr", {31'd0, inst_valid}, 32'd0);
    chk_val("hs_ovr_clr", {31'd0, overrun}, 32'd0);

    // Framing errors: bad stop bit, then a held break.
    f0 = mon_fcnt;
    v0 = mon_vcnt;
    send_byte(8'h55, 1'b0);
    repeat (40) @(negedge clk);
    chk_val("fe_one_pulse", mon_fcnt - f0, 32'd1);
    f0 = mon_fcnt;
    rxd = 1'b0;
    repeat (400) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk_val("fe_break_once", mon_fcnt - f0, 32'd1);
    chk_val("fe_no_word", mon_vcnt - v0, 32'd0);
    send_word(32'h0000_006F);
    repeat (20) @(negedge clk);
    chk_val("fe_recover", mon_last, 32'h0000_006F);
    chk_val("fe_recover_v", mon_vcnt - v0, 32'd1);

    // Stale partial word discarded after the idle timeout.
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    repeat (1000) @(negedge clk);
    send_word(32'h0000_02B7);
    repeat (20) @(negedge clk);
    chk_val("to_discard", mon_last, 32'h0000_02B7);

    // A shorter gap keeps the partial word.
    send_byte(8'h37, 1'b1);
    send_byte(8'h05, 1'b1);
    repeat (500) @(negedge clk);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    chk_val("to_keep", mon_last, 32'h0000_0537);

    // Short glitch is not a start bit.
    f0 = mon_fcnt;
    v0 = mon_vcnt;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    chk_val("gl_no_ferr", mon_fcnt - f0, 32'd0);
    chk_val("gl_no_word", mon_vcnt - v0, 32'd0);
    send_word(32'h1234_5678);
    repeat (20) @(negedge clk);
    chk_val("gl_align", mon_last, 32'h1234_5678);

    // Reset in the middle of the 2nd data bit of a partial word's third byte.
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
    repeat (BIT) @(negedge clk);
    rxd = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    reset = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_val("mr_data", inst_data, 32'd0);
    chk_val("mr_valid", {31'd0, inst_valid}, 32'd0);
    chk_val("mr_ferr", {31'd0, frame_err}, 32'd0);
    chk_val("mr_ovr", {31'd0, overrun}, 32'd0);
    repeat (50) @(negedge clk);
    send_word(32'hDEAD_BEEF);
    repeat (20) @(negedge clk);
    chk_val("mr_word", mon_last, 32'hDEAD_BEEF);
    chk_val("mr_data_reg", inst_data, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_inst_loader.md
UART_INST_LOADER -- requirements
Module: uart_inst_loader

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 208, giving clk cycles per UART bit; legal range 8..65535.
REQ-002 SHALL provide parameter TIMEOUT_CLKS, default 2_400_000, giving the idle clk cycles after which a partial word is discarded.
REQ-003 SHALL provide port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL provide port reset, input, 1, a synchronous, active-high reset.
REQ-005 SHALL provide port rxd, input, 1, asynchronous UART serial input (8N1, LSB first, idle high).
REQ-006 SHALL provide port inst_data, output, 32, the assembled instruction word for the core's external-instruction input.
REQ-007 SHALL provide port inst_valid, output, 1, meaning inst_data holds an unconsumed word.
REQ-008 SHALL provide port inst_ready, input, 1, meaning the consumer accepts the word this cycle.
REQ-009 SHALL provide port frame_err, output, 1, a one-cycle pulse on a bad stop bit.
REQ-010 SHALL provide port overrun, output, 1, a sticky flag set when a word is dropped.
REQ-011 SHALL provide port overrun_clr, input, 1, which clears overrun.

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer whose flops reset to 1; all later references to rx mean the synchronized value.
REQ-013 SHALL implement the receive FSM with states IDLE, START, DATA, STOP.
REQ-014 IDLE SHALL move to START on an rx falling edge (previous 1, current 0), and SHALL clear the bit timer.
REQ-015 START SHALL wait CLKS_PER_BIT/2 cycles (integer divide), then go to DATA if rx=0, else return to IDLE (glitch) with no byte and no error.
REQ-016 DATA SHALL sample rx every CLKS_PER_BIT cycles, shifting it in LSB first, and SHALL enter STOP after the 8th sample.
REQ-017 STOP SHALL sample rx after CLKS_PER_BIT cycles and then return to IDLE.
REQ-018 On the STOP sample, rx=1 SHALL produce a byte strobe.
REQ-019 On the STOP sample, rx=0 SHALL pulse frame_err for exactly one cycle, discard the byte, and clear the byte counter.
REQ-020 After a frame error, IDLE SHALL NOT restart until it sees a fresh falling edge, so a held break produces exactly one frame_err.
REQ-021 The 2-bit byte counter SHALL place byte k into word bits [8k+7:8k] (little-endian), incrementing modulo 4 on each byte strobe.
REQ-022 The 4th byte strobe SHALL complete a word.
REQ-023 On completion, if inst_valid=0 or inst_ready=1 in that cycle, the word SHALL be loaded into inst_data and inst_valid SHALL be 1 on the next cycle (latency 1 clk after the 4th stop-bit sample).
REQ-024 On completion with inst_valid=1 and inst_ready=0, the word SHALL be dropped, overrun set, and inst_data left unchanged.
REQ-025 inst_valid SHALL clear on the cycle after inst_valid&inst_ready with no simultaneous completion; a simultaneous completion keeps inst_valid=1 with the new data.
REQ-026 inst_data SHALL be stable while inst_valid=1 and inst_ready=0.
REQ-027 While byte counter≠0 and FSM=IDLE, an idle counter SHALL run; on reaching TIMEOUT_CLKS it SHALL clear the byte counter and itself; any falling edge clears it.
REQ-028 If overrun_clr and a new overrun event coincide, overrun SHALL remain 1 (set wins).
REQ-029 Bit-timer and idle-counter widths SHALL be sized by $clog2 of their parameters; no counter may wrap before its terminal count.

Reset
REQ-030 While reset=1 at a clk edge: FSM=IDLE, synchronizer=2'b11, byte counter=0, timers=0, inst_data=0, inst_valid=0, frame_err=0, overrun=0.
REQ-031 Reset asserted mid-frame or mid-word SHALL abandon all partial state; the first word after reset is built only from bytes whose start bit begins after reset deasserts.

Verification (CLKS_PER_BIT=16, TIMEOUT_CLKS=1000)
REQ-032 Bytes 0x13,0x00,0x00,0x00 with inst_ready=1 -> inst_data=0x00000013, inst_valid high 1 cycle, 1 clk after the last stop sample.
REQ-033 Two words 0x00100093 and 0x00208113 with inst_ready=0 -> first held stable, second dropped, overrun=1; overrun_clr -> overrun=0.
REQ-034 Byte 0x55 with stop bit=0 -> one frame_err pulse, no word; then 4 good bytes 0x6F,0x00,0x00,0x00 -> 0x0000006F.
REQ-035 Two bytes, 1000-cycle idle gap, then 4 bytes 0xB7,0x02,0x00,0x00 -> inst_data=0x000002B7 (stale bytes discarded).
REQ-036 Zero pulse of 4 clk on rxd -> no byte, no frame_err; reset during the 2nd data bit -> all outputs 0, and the next full word is received correctly.
